// File: rtl/config_burst_loader.sv
// Burst initiator for the Control Path configuration write bus: one word per
// target-thread slot, registered address/data presented the cycle after each handshake.
module config_burst_loader #(
    parameter int unsigned ADDR_WIDTH         = 10,
    parameter int unsigned WORD_WIDTH         = 36,
    parameter int unsigned COUNT_WIDTH        = 10,
    parameter int unsigned THREAD_COUNT       = 8,
    parameter int unsigned THREAD_COUNT_WIDTH = 3,
    parameter int unsigned IDLE_ADDR          = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [THREAD_COUNT_WIDTH-1:0] current_thread,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ADDR_WIDTH-1:0]         cmd_base_addr,
    input  logic [COUNT_WIDTH-1:0]        cmd_length,
    input  logic [THREAD_COUNT_WIDTH-1:0] cmd_thread,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic [WORD_WIDTH-1:0]         data_word,
    output logic                          config_write,
    output logic [ADDR_WIDTH-1:0]         config_addr,
    output logic [WORD_WIDTH-1:0]         config_data,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] data;
    } cfg_wr_t;

    localparam cfg_wr_t CFG_IDLE = '{write: 1'b0, addr: ADDR_WIDTH'(IDLE_ADDR), data: '0};

    state_t                          state;
    state_t                          state_next;
    logic [ADDR_WIDTH-1:0]           next_addr;
    logic [COUNT_WIDTH-1:0]          remaining;
    logic [THREAD_COUNT_WIDTH-1:0]   target;
    cfg_wr_t                         cfg_wr;
    logic                            cmd_fire;
    logic                            data_fire;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign data_fire = data_valid && data_ready;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a zero-length burst goes straight to the completion cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_next = (cmd_length == '0) ? FINISH : LOAD;
                end
            end
            LOAD: begin
                if (data_fire && (remaining == COUNT_WIDTH'(1))) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        cmd_ready  = 1'b0;
        data_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !reset;
                busy      = 1'b0;
            end
            LOAD:    data_ready = (current_thread == target);
            FINISH:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Burst context: latched at accept, advanced per consumed word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            next_addr <= '0;
            remaining <= '0;
            target    <= '0;
        end else if (cmd_fire) begin
            next_addr <= cmd_base_addr;
            remaining <= cmd_length;
            target    <= cmd_thread;
        end else if (data_fire) begin
            next_addr <= next_addr + ADDR_WIDTH'(1);
            remaining <= remaining - COUNT_WIDTH'(1);
        end
    end

    // Write port register: holds a write for exactly one cycle, idle pattern otherwise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_wr <= CFG_IDLE;
        end else if (data_fire) begin
            cfg_wr <= '{write: 1'b1, addr: next_addr, data: data_word};
        end else begin
            cfg_wr <= CFG_IDLE;
        end
    end

    assign config_write = cfg_wr.write;
    assign config_addr  = cfg_wr.addr;
    assign config_data  = cfg_wr.data;

    a_ready_exclusive: assert property (@(posedge clock) disable iff (reset)
        !(cmd_ready && data_ready));

    a_thread_in_range: assert property (@(posedge clock) disable iff (reset)
        32'(current_thread) < THREAD_COUNT);

    a_load_has_work: assert property (@(posedge clock) disable iff (reset)
        (state != LOAD) || (remaining != '0));

endmodule

// File: tb/tb_config_burst_loader.sv
// Scoreboard bench for config_burst_loader: directed bursts push expected writes,
// a negedge monitor pops and checks each presented write.
module tb_config_burst_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  current_thread = 3'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_base_addr = 10'd0;
    logic [9:0]  cmd_length = 10'd0;
    logic [2:0]  cmd_thread = 3'd0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [35:0] data_word = 36'd0;
    logic        config_write;
    logic [9:0]  config_addr;
    logic [35:0] config_data;
    logic        busy;
    logic        done;

    config_burst_loader #(
        .ADDR_WIDTH(10), .WORD_WIDTH(36), .COUNT_WIDTH(10),
        .THREAD_COUNT(8), .THREAD_COUNT_WIDTH(3), .IDLE_ADDR(0)
    ) dut (
        .clock(clock), .reset(reset), .current_thread(current_thread),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base_addr(cmd_base_addr),
        .cmd_length(cmd_length), .cmd_thread(cmd_thread),
        .data_valid(data_valid), .data_ready(data_ready), .data_word(data_word),
        .config_write(config_write), .config_addr(config_addr), .config_data(config_data),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [9:0]  addr;
        logic [35:0] data;
        logic [2:0]  thr;
        int          gap;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cyc = -1;
    int          last_wr_cyc = -1;
    logic        busy_after_done = 1'b1;
    logic        cmd_ready_after_done = 1'b0;
    logic        done_prev = 1'b0;
    logic [2:0]  prev_thread = 3'd0;
    logic [2:0]  cur_target = 3'd0;
    int          excl_viol = 0;
    int          slot_viol = 0;
    int          idle_viol = 0;

    always #5 clock = ~clock;

    // Cycle counter and free-running barrel thread slot
    initial begin
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
            #1 current_thread = current_thread + 3'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [9:0] a, input logic [35:0] d, input logic [2:0] t, input int gap);
        exp_t e;
        e.addr = a; e.data = d; e.thr = t; e.gap = gap;
        sb.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every presented write
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (cmd_ready && data_ready) excl_viol = excl_viol + 1;
            if (data_ready && (current_thread != cur_target)) slot_viol = slot_viol + 1;
            if (!config_write && (config_addr != 10'd0 || config_data != 36'd0)) idle_viol = idle_viol + 1;
            if (done_prev) begin
                busy_after_done = busy;
                cmd_ready_after_done = cmd_ready;
            end
            done_prev = done;
            if (done) done_cyc = cyc;
            if (config_write) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 64'(config_write), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 64'(config_addr), 64'(e.addr));
                    check("wr_data", 64'(config_data), 64'(e.data));
                    check("wr_slot", 64'(prev_thread), 64'(e.thr));
                    if (e.gap != 0) check("wr_gap", 64'(cyc - last_wr_cyc), 64'(e.gap));
                end
                last_wr_cyc = cyc;
            end
            prev_thread = current_thread;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic send_cmd(input logic [9:0] base, input logic [9:0] len, input logic [2:0] thr,
                            output int acc);
        logic ok;
        ok  = 1'b0;
        acc = -1;
        @(posedge clock); #2;
        cmd_valid = 1'b1; cmd_base_addr = base; cmd_length = len; cmd_thread = thr;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (cmd_ready) begin
                acc = cyc; cur_target = thr; ok = 1'b1;
                break;
            end
            @(posedge clock); #2;
        end
        @(posedge clock); #2;
        // Scrambled fields after accept must be ignored by the loader
        cmd_valid = 1'b0; cmd_base_addr = 10'h3AB; cmd_length = 10'd7; cmd_thread = 3'd7;
        check("cmd_accept", 64'(ok), 64'(1));
    endtask

    task automatic send_data(input logic [35:0] w [8], input int n, input int stall_word,
                             input logic [2:0] thr);
        logic stalled;
        logic ok;
        stalled = 1'b0;
        for (int i = 0; i < n; i++) begin
            ok = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(posedge clock); #2;
                data_word = w[i];
                if (i == stall_word && !stalled && current_thread == thr) begin
                    data_valid = 1'b0;
                    stalled = 1'b1;
                end else begin
                    data_valid = 1'b1;
                end
                @(negedge clock);
                if (data_valid && data_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("data_accept", 64'(ok), 64'(1));
        end
        @(posedge clock); #2;
        data_valid = 1'b0;
    endtask

    initial begin
        logic [35:0] w [8];
        int acc;
        int acc2;

        // Reset values
        wait_cycles(2); #2;
        check("rst_write", 64'(config_write), 64'(0));
        check("rst_addr", 64'(config_addr), 64'(0));
        check("rst_data", 64'(config_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_data_ready", 64'(data_ready), 64'(0));
        reset = 1'b0;
        @(negedge clock);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));

        // Basic burst
        w = '{36'hA, 36'hB, 36'hC, 0, 0, 0, 0, 0};
        push(10'h100, 36'hA, 3'd2, 0);
        push(10'h101, 36'hB, 3'd2, 8);
        push(10'h102, 36'hC, 3'd2, 8);
        send_cmd(10'h100, 10'd3, 3'd2, acc);
        #1 check("busy_after_accept", 64'(busy), 64'(1));
        send_data(w, 3, -1, 3'd2);
        wait_cycles(3);
        check("basic_done_with_last", 64'(done_cyc), 64'(last_wr_cyc));
        check("basic_busy_drop", 64'(busy_after_done), 64'(0));
        check("basic_sb_empty", 64'(sb.size()), 64'(0));

        // Data stall in second slot
        w = '{36'h11, 36'h22, 36'h33, 0, 0, 0, 0, 0};
        push(10'h100, 36'h11, 3'd2, 0);
        push(10'h101, 36'h22, 3'd2, 16);
        push(10'h102, 36'h33, 3'd2, 8);
        send_cmd(10'h100, 10'd3, 3'd2, acc);
        send_data(w, 3, 1, 3'd2);
        wait_cycles(3);
        check("stall_sb_empty", 64'(sb.size()), 64'(0));

        // Zero length
        send_cmd(10'h050, 10'd0, 3'd4, acc);
        wait_cycles(4);
        check("zero_done_cycle", 64'(done_cyc), 64'(acc + 1));
        check("zero_cmd_ready_after", 64'(cmd_ready_after_done), 64'(1));
        check("zero_sb_empty", 64'(sb.size()), 64'(0));

        // Address wrap
        w = '{36'h111, 36'h222, 0, 0, 0, 0, 0, 0};
        push(10'h3FF, 36'h111, 3'd5, 0);
        push(10'h000, 36'h222, 3'd5, 8);
        send_cmd(10'h3FF, 10'd2, 3'd5, acc);
        send_data(w, 2, -1, 3'd5);
        wait_cycles(3);
        check("wrap_sb_empty", 64'(sb.size()), 64'(0));

        // Back-to-back: second command waits for the cycle after done
        w = '{36'h0F0, 36'h0F1, 0, 0, 0, 0, 0, 0};
        push(10'h200, 36'h0F0, 3'd6, 0);
        push(10'h201, 36'h0F1, 3'd6, 8);
        push(10'h300, 36'h3, 3'd1, 0);
        send_cmd(10'h200, 10'd2, 3'd6, acc);
        fork
            send_data(w, 2, -1, 3'd6);
            send_cmd(10'h300, 10'd1, 3'd1, acc2);
        join
        check("b2b_accept_after_done", 64'(acc2), 64'(done_cyc + 1));
        w = '{36'h3, 0, 0, 0, 0, 0, 0, 0};
        send_data(w, 1, -1, 3'd1);
        wait_cycles(3);
        check("b2b_sb_empty", 64'(sb.size()), 64'(0));

        // Reset mid-burst after two of five words
        w = '{36'h1, 36'h2, 36'h3, 36'h4, 36'h5, 0, 0, 0};
        push(10'h010, 36'h1, 3'd3, 0);
        push(10'h011, 36'h2, 3'd3, 8);
        send_cmd(10'h010, 10'd5, 3'd3, acc);
        send_data(w, 2, -1, 3'd3);
        @(negedge clock);
        check("pre_reset_write", 64'(config_write), 64'(1));
        #1 reset = 1'b1;
        #1;
        check("mid_rst_write", 64'(config_write), 64'(0));
        check("mid_rst_addr", 64'(config_addr), 64'(0));
        check("mid_rst_data", 64'(config_data), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_data_ready", 64'(data_ready), 64'(0));
        wait_cycles(2); #2;
        reset = 1'b0;
        data_word = 36'h3; data_valid = 1'b1;
        @(negedge clock);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        wait_cycles(16); #2;
        data_valid = 1'b0;
        check("post_rst_no_write", 64'(sb.size()), 64'(0));
        w = '{36'h99, 0, 0, 0, 0, 0, 0, 0};
        push(10'h080, 36'h99, 3'd4, 0);
        send_cmd(10'h080, 10'd1, 3'd4, acc);
        send_data(w, 1, -1, 3'd4);
        wait_cycles(3);
        check("post_rst_sb_empty", 64'(sb.size()), 64'(0));

        check("ready_exclusive", 64'(excl_viol), 64'(0));
        check("data_ready_slot", 64'(slot_viol), 64'(0));
        check("idle_pattern", 64'(idle_viol), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
